// File: rtl/upd7800_bus_pkg.sv
// Shared types and defaults for the uPD7800 bus responder: FSM state encoding,
// default work-RAM window placement and the window-hit helper.
package upd7800_bus_pkg;

  typedef enum logic [2:0] {
    BRS_IDLE     = 3'd0,
    BRS_RD_RAM   = 3'd1,
    BRS_RD_MEM   = 3'd2,
    BRS_RD_DRIVE = 3'd3,
    BRS_RD_DRAIN = 3'd4,
    BRS_WR_MEM   = 3'd5
  } e_brs;

  localparam logic [15:0] WRAM_BASE_DEF = 16'hFF80;
  localparam int          WRAM_AW_DEF   = 7;

  // The window always runs to the top of the address space, so a single compare suffices.
  function automatic logic wram_hit(input logic [15:0] addr, input logic [15:0] base);
    return (addr >= base);
  endfunction

endpackage

// File: rtl/upd7800_wram.sv
// Single-port synchronous work RAM, 2^AW bytes, one read/write port, 1-cycle read latency.
module upd7800_wram #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  // Contents are deliberately not reset; read returns the old byte on a write cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/upd7800_bus_responder.sv
// uPD7800 bus responder: serves the internal work-RAM window (enabled by UPD7800_WRAM_EN)
// and forwards every other access to a request/acknowledge backend port.
module upd7800_bus_responder
  import upd7800_bus_pkg::*;
#(
  parameter logic [15:0] WRAM_BASE = WRAM_BASE_DEF,
  parameter int          WRAM_AW   = WRAM_AW_DEF
) (
  input  logic        CLK,
  input  logic        RESETB,
  input  logic [15:0] A,
  input  logic [7:0]  DB_I,
  output logic [7:0]  DB_O,
  output logic        DB_OE,
  input  logic        RDB,
  input  logic        WRB,
  input  logic        M1,
  output logic [15:0] MEM_A,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic [7:0]  MEM_DO,
  input  logic [7:0]  MEM_DI,
  input  logic        MEM_ACK,
  output logic [15:0] FETCH_CNT,
  output logic        LATE,
  output logic        ERR
);

  e_brs        state;
  logic        rdb_q;
  logic        wrb_q;
  logic        both_low_q;
  logic        wr_cancel;
  logic [15:0] a_q;
  logic [7:0]  dbi_q;
  logic [15:0] fetch_cnt;

  logic        is_idle;
  logic        rd_fall;
  logic        wr_rise;
  logic        both_low;
  logic        both_low_first;
  logic        rd_start;
  logic        wr_start;
  logic        err_cond;
  logic        hit_rd;
  logic        hit_wr;

  assign is_idle        = (state == BRS_IDLE);
  assign rd_fall        = rdb_q & ~RDB;
  assign wr_rise        = ~wrb_q & WRB;
  assign both_low       = ~RDB & ~WRB;
  assign both_low_first = both_low & ~both_low_q;
  assign rd_start       = is_idle & rd_fall & WRB;
  // A write whose low phase overlapped a read strobe has already been flagged and is dropped.
  assign wr_start       = is_idle & wr_rise & ~wr_cancel;
  assign err_cond       = both_low_first
                        | (rd_fall & ~is_idle)
                        | (wr_rise & ~is_idle & ~wr_cancel);

  assign DB_OE     = (state == BRS_RD_DRIVE) & ~RDB;
  assign FETCH_CNT = fetch_cnt;

`ifdef UPD7800_WRAM_EN
  logic               ram_we;
  logic [WRAM_AW-1:0] ram_addr;
  logic [7:0]         ram_rdata;

  assign hit_rd   = wram_hit(A, WRAM_BASE);
  assign hit_wr   = wram_hit(a_q, WRAM_BASE);
  assign ram_we   = wr_start & hit_wr;
  // Reads present the live bus address so the data is ready one edge after the strobe edge.
  assign ram_addr = ram_we ? a_q[WRAM_AW-1:0] : A[WRAM_AW-1:0];

  upd7800_wram #(
    .AW    (WRAM_AW)
  ) u_wram (
    .clk   (CLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (dbi_q),
    .rdata (ram_rdata)
  );
`else
  logic unused_cfg;

  assign hit_rd     = 1'b0;
  assign hit_wr     = 1'b0;
  assign unused_cfg = ^{WRAM_BASE, 8'(WRAM_AW)};
`endif

  // Strobe history, write capture, error/late pulses, fetch counter and the access FSM.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state      <= BRS_IDLE;
      rdb_q      <= 1'b1;
      wrb_q      <= 1'b1;
      both_low_q <= 1'b0;
      wr_cancel  <= 1'b0;
      a_q        <= 16'h0000;
      dbi_q      <= 8'h00;
      fetch_cnt  <= 16'h0000;
      DB_O       <= 8'hFF;
      MEM_A      <= 16'h0000;
      MEM_DO     <= 8'h00;
      MEM_RD     <= 1'b0;
      MEM_WR     <= 1'b0;
      LATE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      rdb_q      <= RDB;
      wrb_q      <= WRB;
      both_low_q <= both_low;
      a_q        <= A;
      dbi_q      <= DB_I;
      ERR        <= err_cond;
      LATE       <= 1'b0;

      if (both_low_first) begin
        wr_cancel <= 1'b1;
      end else if (WRB) begin
        wr_cancel <= 1'b0;
      end else begin
        wr_cancel <= wr_cancel;
      end

      if (rd_start && M1) begin
        fetch_cnt <= fetch_cnt + 16'd1;
      end

      case (state)
        BRS_IDLE: begin
          if (rd_start) begin
            if (hit_rd) begin
              state <= BRS_RD_RAM;
            end else begin
              MEM_A  <= A;
              MEM_RD <= 1'b1;
              state  <= BRS_RD_MEM;
            end
          end else if (wr_start && !hit_wr) begin
            MEM_A  <= a_q;
            MEM_DO <= dbi_q;
            MEM_WR <= 1'b1;
            state  <= BRS_WR_MEM;
          end
        end
`ifdef UPD7800_WRAM_EN
        BRS_RD_RAM: begin
          DB_O  <= ram_rdata;
          state <= BRS_RD_DRIVE;
        end
`endif
        BRS_RD_MEM: begin
          if (MEM_ACK) begin
            DB_O   <= MEM_DI;
            MEM_RD <= 1'b0;
            state  <= BRS_RD_DRIVE;
          end else if (RDB) begin
            // CPU gave up before the backend answered; the request must still be drained.
            LATE  <= 1'b1;
            state <= BRS_RD_DRAIN;
          end
        end
        BRS_RD_DRIVE: begin
          if (RDB) begin
            state <= BRS_IDLE;
          end
        end
        BRS_RD_DRAIN: begin
          if (MEM_ACK) begin
            MEM_RD <= 1'b0;
            state  <= BRS_IDLE;
          end
        end
        BRS_WR_MEM: begin
          if (MEM_ACK) begin
            MEM_WR <= 1'b0;
            state  <= BRS_IDLE;
          end
        end
        default: begin
          MEM_RD <= 1'b0;
          MEM_WR <= 1'b0;
          state  <= BRS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/upd7800_bus_responder.md
# upd7800_bus_responder

Bus-side responder for the uPD7800 external interface. It watches the CPU's address bus, data bus and read/write/M1 strobes, and services each access. Accesses in the on-chip work-RAM window (FF80h–FFFFh by default) are handled internally. All other accesses are forwarded to a backend memory port through a request/acknowledge handshake. It sits between the CPU core and the cartridge/system memory map and returns read data on the CPU's input data bus.

## Interface
- `WRAM_BASE`, default 16'hFF80: first address of the internal work-RAM window; the window ends at FFFFh.
- `WRAM_AW`, default 7: work-RAM address width, giving 2^WRAM_AW bytes. WRAM_BASE + 2^WRAM_AW must equal 10000h.
- `CLK` input, 1 bit: system clock, the same clock that drives the CPU core.
- `RESETB` input, 1 bit: reset, asynchronous and active-low.
- `A` input, 16 bits: CPU address bus.
- `DB_I` input, 8 bits: write data driven by the CPU.
- `DB_O` output, 8 bits: read data returned to the CPU.
- `DB_OE` output, 1 bit: read-data drive enable.
- `RDB` input, 1 bit: CPU read strobe, active-low.
- `WRB` input, 1 bit: CPU write strobe, active-low.
- `M1` input, 1 bit: marks an opcode-fetch cycle.
- `MEM_A` output, 16 bits: backend address.
- `MEM_RD` output, 1 bit: backend read request.
- `MEM_WR` output, 1 bit: backend write request.
- `MEM_DO` output, 8 bits: backend write data.
- `MEM_DI` input, 8 bits: backend read data, valid in the cycle `MEM_ACK` is high.
- `MEM_ACK` input, 1 bit: backend acknowledge. It is a 1-cycle pulse and arrives at least 1 cycle after the request rises.
- `FETCH_CNT` output, 16 bits: count of M1 reads.
- `LATE` output, 1 bit: 1-cycle pulse when a read strobe ends before its data was ready.
- `ERR` output, 1 bit: 1-cycle pulse on a protocol violation.

## Operation
- Strobes are synchronous to `CLK` and are not resynchronised. `RDB` and `WRB` are registered once per cycle for edge detection.
- Window hit condition: `A >= WRAM_BASE`.
- States: IDLE, RD_RAM, RD_MEM, RD_DRIVE, RD_DRAIN, WR_MEM.
- **Read start:** in IDLE, a falling edge of `RDB` with `WRB` high latches `A` into an address register.
  - On a window hit: go to RD_RAM. The synchronous RAM read completes, `DB_O` loads the RAM data, then go to RD_DRIVE.
  - On a miss: go to RD_MEM. `MEM_A` takes the latched address and `MEM_RD` is held high until `MEM_ACK`. On ack, `DB_O` loads `MEM_DI` and `MEM_RD` drops in the same edge; go to RD_DRIVE.
- **RD_DRIVE:** hold `DB_O` until `RDB` is sampled high, then return to IDLE.
- **DB_OE:** equals (state is RD_DRIVE) AND NOT `RDB`. It drops combinationally when `RDB` rises.
- **Late read:**
  - If `RDB` rises while in RD_MEM, pulse `LATE` and go to RD_DRAIN.
  - RD_DRAIN keeps `MEM_RD` asserted until `MEM_ACK`, discards the data, and returns to IDLE.
  - `DB_O` is unchanged by a late read.
- **Write:**
  - A write is captured on the rising edge of `WRB`, i.e. sampled high after having been low. `A` and `DB_I` are captured from the cycle before the rise.
  - On a window hit, the RAM byte is written in that same edge and the block stays in IDLE.
  - On a miss, go to WR_MEM. `MEM_A`, `MEM_DO` and `MEM_WR` are held until `MEM_ACK`, then return to IDLE.
- **Fetch counter:** `FETCH_CNT` increments on each accepted `RDB` falling edge with `M1` high. It wraps FFFFh to 0000h.
- **Boundary cases:**
  - `RDB` and `WRB` both low in the same cycle (first such cycle): pulse `ERR`. No access is started, and the pending write edge is cancelled.
  - `RDB` falling or `WRB` rising while not in IDLE: pulse `ERR` and ignore the strobe.
  - `MEM_ACK` while no request is pending: ignored.
- **Reset** (asynchronous, any state):
  - State goes to IDLE.
  - `DB_O` = FFh.
  - `DB_OE`, `MEM_RD`, `MEM_WR`, `LATE` and `ERR` = 0.
  - `MEM_A` = 0000h, `MEM_DO` = 00h, `FETCH_CNT` = 0000h.
  - Work-RAM contents are not reset.

## Timing
- Read, window hit: `DB_O` is valid and `DB_OE` is high 2 cycles after the `RDB` fall is sampled (cycle 1: latch/RAM address, cycle 2: RAM data).
- Read, miss: `MEM_RD` rises 1 cycle after the `RDB` fall is sampled. `DB_O` is valid 1 cycle after `MEM_ACK`.
- Write, window hit: RAM is updated 1 cycle after the `WRB` rise is sampled.
- Write, miss: `MEM_WR` rises 1 cycle after the `WRB` rise is sampled and falls 1 cycle after `MEM_ACK`.
- `LATE` and `ERR` are registered 1-cycle pulses that rise the cycle after the triggering sample.
- The backend must acknowledge within the CPU's strobe width minus 3 cycles; otherwise `LATE` results.

## Configuration
- `UPD7800_WRAM_EN` defined: the work-RAM window is served internally as described above.
- `UPD7800_WRAM_EN` undefined:
  - No RAM is instantiated and every address misses, so all accesses go to the backend port.
  - The RD_RAM state does not exist.
  - `WRAM_BASE` and `WRAM_AW` are ignored.

## Structure
- Shared package `upd7800_bus_pkg` holds:
  - the state enum `e_brs` (BRS_IDLE, BRS_RD_RAM, BRS_RD_MEM, BRS_RD_DRIVE, BRS_RD_DRAIN, BRS_WR_MEM);
  - the default window constants.
- Sub-module `upd7800_wram`: a single-port synchronous RAM with parameter `AW`, one read/write port, and 1-cycle read latency.

## Test plan
- Write 5Ah to FF90h (window hit), then read FF90h: `MEM_WR` never asserts, and `DB_O` = 5Ah with `DB_OE` high during `RDB` low.
- Read 1234h with `MEM_ACK` 4 cycles after `MEM_RD` and `MEM_DI` = C3h: `MEM_A` = 1234h, and `DB_O` = C3h 1 cycle after the ack.
- Read 2000h with `RDB` released before a delayed ack: `LATE` pulses once, `MEM_RD` stays high until the ack, and `DB_O` keeps its previous value.
- Three M1 reads starting at FETCH_CNT = FFFEh: the count runs FFFFh, 0000h, 0001h. Non-M1 reads leave it unchanged.
- `RDB` and `WRB` driven low together: `ERR` pulses, with no backend request and no RAM change. A `WRB` rise during RD_MEM: `ERR` pulses and the write is dropped.
- `RESETB` asserted during WR_MEM: `MEM_WR` = 0 immediately, and after release the block is in IDLE with `DB_O` = FFh and `FETCH_CNT` = 0.
